// File: rtl/mips_data_bus_bridge.sv
// rtl/mips_data_bus_bridge.sv - Harvard core data port to Avalon-MM master bridge with one-word read cache
module mips_data_bus_bridge #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_stall,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        bus_error
);

  localparam int unsigned CNT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_REQ       = 2'd1;
  localparam logic [1:0] S_WAIT_DATA = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  logic [1:0]       r_state;
  logic             r_cache_valid;
  logic [29:0]      r_cache_addr;
  logic [31:0]      r_cache_data;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_bus_error;
  logic             r_is_write;
  logic             r_avm_read;
  logic             r_avm_write;
  logic [31:0]      r_avm_address;
  logic [31:0]      r_avm_writedata;

  logic w_hit;
  logic w_busy;
  logic w_accept;
  logic w_expired;

  // A hit is only possible for a pure read; any write goes to the bus.
  assign w_hit     = r_cache_valid && (r_cache_addr == cpu_address[31:2]) && cpu_read && !cpu_write;
  assign w_busy    = (r_state == S_REQ) || (r_state == S_WAIT_DATA);
  assign w_accept  = (r_state == S_REQ) && !avm_waitrequest;
  // The cycle with count MAX_WAIT-1 is the last one allowed; abort if it does not complete.
  assign w_expired = w_busy && (r_wait_cnt >= WAIT_LAST);

  // Stall is gated by reset so the core is never frozen while the bridge is held in reset.
  assign cpu_stall = reset && ((((cpu_read || cpu_write) && !w_hit) && (r_state != S_DONE)) || w_busy);

  assign cpu_readdata   = r_cache_valid ? r_cache_data : 32'd0;
  assign avm_address    = r_avm_address;
  assign avm_read       = r_avm_read;
  assign avm_write      = r_avm_write;
  assign avm_writedata  = r_avm_writedata;
  assign avm_byteenable = 4'hF;
  assign bus_error      = r_bus_error;

  // Transaction sequencer, cache register, wait counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_cache_valid   <= 1'b0;
      r_cache_addr    <= '0;
      r_cache_data    <= '0;
      r_wait_cnt      <= '0;
      r_bus_error     <= 1'b0;
      r_is_write      <= 1'b0;
      r_avm_read      <= 1'b0;
      r_avm_write     <= 1'b0;
      r_avm_address   <= '0;
      r_avm_writedata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_wait_cnt <= '0;
          if (cpu_write) begin
            r_avm_address   <= cpu_address & 32'hFFFF_FFFC;
            r_avm_writedata <= cpu_writedata;
            r_avm_write     <= 1'b1;
            r_is_write      <= 1'b1;
            r_cache_valid   <= 1'b0;
            r_state         <= S_REQ;
          end else if (cpu_read && !w_hit) begin
            r_avm_address <= cpu_address & 32'hFFFF_FFFC;
            r_avm_read    <= 1'b1;
            r_is_write    <= 1'b0;
            r_state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_accept) begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            if (r_is_write) begin
              r_state <= S_DONE;
            end else if (avm_readdatavalid) begin
              r_cache_data  <= avm_readdata;
              r_cache_addr  <= r_avm_address[31:2];
              r_cache_valid <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              r_state <= S_WAIT_DATA;
              if (r_wait_cnt != CNT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end else if (w_expired) begin
            r_avm_read    <= 1'b0;
            r_avm_write   <= 1'b0;
            r_bus_error   <= 1'b1;
            r_cache_data  <= '0;
            r_cache_addr  <= r_avm_address[31:2];
            r_cache_valid <= !r_is_write;
            r_state       <= S_DONE;
          end else if (r_wait_cnt != CNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_WAIT_DATA: begin
          if (avm_readdatavalid) begin
            r_cache_data  <= avm_readdata;
            r_cache_addr  <= r_avm_address[31:2];
            r_cache_valid <= 1'b1;
            r_state       <= S_DONE;
          end else if (w_expired) begin
            r_bus_error   <= 1'b1;
            r_cache_data  <= '0;
            r_cache_addr  <= r_avm_address[31:2];
            r_cache_valid <= 1'b1;
            r_state       <= S_DONE;
          end else if (r_wait_cnt != CNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_wait_cnt <= '0;
          if (r_is_write) r_cache_valid <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// tb/tb_mips_data_bus_bridge.sv - randomized self-checking bench for mips_data_bus_bridge
module tb_mips_data_bus_bridge;

  localparam int MAXW = 8;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_stall;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        bus_error;

  int n_checks;
  int n_errors;

  // reference model: one cached word plus the sticky error flag
  logic        m_valid;
  logic [29:0] m_addr;
  logic [31:0] m_data;
  logic        m_err;

  mips_data_bus_bridge #(.MAX_WAIT(MAXW)) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_address       (cpu_address),
    .cpu_read          (cpu_read),
    .cpu_write         (cpu_write),
    .cpu_writedata     (cpu_writedata),
    .cpu_readdata      (cpu_readdata),
    .cpu_stall         (cpu_stall),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .bus_error         (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outcome of one core request, derived from the cache rules; updates the model.
  task automatic model_step(input logic rd, input logic wr, input logic [31:0] addr,
                            input int waits, input int lat, input logic [31:0] rdata,
                            input logic tmo, output int e_stall, output int e_rc,
                            output int e_wc, output logic [31:0] e_ro);
    logic hit;
    hit = m_valid && (m_addr == addr[31:2]) && rd && !wr;
    e_rc = 0;
    e_wc = 0;
    if (hit) begin
      e_stall = 0;
    end else if (wr) begin
      e_stall = waits + 2;
      e_wc = waits + 1;
      m_valid = 1'b0;
    end else if (rd) begin
      m_valid = 1'b1;
      m_addr = addr[31:2];
      if (tmo) begin
        e_stall = 1 + MAXW;
        e_rc = MAXW;
        m_data = 32'd0;
        m_err = 1'b1;
      end else begin
        e_stall = waits + 2 + lat;
        e_rc = waits + 1;
        m_data = rdata;
      end
    end else begin
      e_stall = 0;
    end
    e_ro = m_valid ? m_data : 32'd0;
  endtask

  // Drives one core request plus a slave that waits and returns data as told; called at a negedge.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input int lat,
                         input logic [31:0] rdata, output int stall_cyc, output int wr_cyc,
                         output int rd_cyc, output int both_cyc, output logic [31:0] rd_out,
                         output logic [31:0] bus_addr, output logic [31:0] bus_wdata,
                         output logic [3:0] bus_be, output logic hung);
    int strobe_n;
    int since_acc;
    logic acc;
    logic fin;
    stall_cyc = 0; wr_cyc = 0; rd_cyc = 0; both_cyc = 0;
    rd_out = '0; bus_addr = '0; bus_wdata = '0; bus_be = '0;
    hung = 1'b1; strobe_n = 0; since_acc = 0; acc = 1'b0; fin = 1'b0;
    cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_writedata = wdata;
    for (int c = 0; c < 200 && !fin; c++) begin
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata = ~rdata;
      if (acc) since_acc++;
      if (avm_read || avm_write) begin
        if (strobe_n == 0) begin
          bus_addr = avm_address; bus_wdata = avm_writedata; bus_be = avm_byteenable;
        end
        strobe_n++;
        if (avm_read) rd_cyc++;
        if (avm_write) wr_cyc++;
        if (avm_read && avm_write) both_cyc++;
        if (strobe_n > waits) begin
          acc = 1'b1;
          since_acc = 0;
        end else begin
          avm_waitrequest = 1'b1;
        end
      end
      if (acc && rd && !wr && since_acc == lat) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = rdata;
      end
      #1;
      if (cpu_stall) stall_cyc++;
      else begin
        fin = 1'b1;
        hung = 1'b0;
        rd_out = cpu_readdata;
      end
      @(negedge clk);
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h1000_0004; cpu_writedata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    m_valid = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
    #3;
    n_checks++;
    if ({avm_read, avm_write, avm_address, avm_writedata, cpu_readdata, bus_error} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h wd=%h rdata=%h err=%b required all 0",
               avm_read, avm_write, avm_address, avm_writedata, cpu_readdata, bus_error);
    end
    n_checks++;
    if (cpu_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_stall: got %b required 0", cpu_stall);
    end
    n_checks++;
    if (avm_byteenable !== 4'hF) begin
      n_errors++;
      $display("FAIL reset_byteenable: got %h required f", avm_byteenable);
    end
    @(negedge clk);
    cpu_read = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_wait_read();
    int st, wc, rc, bc, es, erc, ewc;
    logic [31:0] ro, ba, bw, ero;
    logic [3:0] be;
    logic hg;
    model_step(1, 0, 32'h1000_0004, 0, 1, 32'hCAFE_F00D, 0, es, erc, ewc, ero);
    run_txn(1, 0, 32'h1000_0004, 0, 0, 1, 32'hCAFE_F00D, st, wc, rc, bc, ro, ba, bw, be, hg);
    n_checks++;
    if (hg !== 1'b0 || st !== 3) begin
      n_errors++; $display("FAIL zw_read_stall: got %0d (hung=%b) required 3", st, hg);
    end
    n_checks++;
    if (ro !== 32'hCAFE_F00D) begin
      n_errors++; $display("FAIL zw_read_data: got %h required cafef00d", ro);
    end
    n_checks++;
    if (ba !== 32'h1000_0004 || rc !== 1) begin
      n_errors++; $display("FAIL zw_read_bus: got addr=%h rd_cycles=%0d required 10000004/1", ba, rc);
    end
    model_step(1, 0, 32'h1000_0004, 0, 1, 32'h0, 0, es, erc, ewc, ero);
    run_txn(1, 0, 32'h1000_0004, 0, 0, 1, 32'h5555_AAAA, st, wc, rc, bc, ro, ba, bw, be, hg);
    n_checks++;
    if (st !== 0 || rc !== 0 || ro !== 32'hCAFE_F00D) begin
      n_errors++;
      $display("FAIL zw_read_hit: got stall=%0d rd_cycles=%0d data=%h required 0/0/cafef00d", st, rc, ro);
    end
  endtask

  task automatic test_write_waits();
    int st, wc, rc, bc, es, erc, ewc;
    logic [31:0] ro, ba, bw, ero;
    logic [3:0] be;
    logic hg;
    model_step(0, 1, 32'h2000_0003, 4, 0, 0, 0, es, erc, ewc, ero);
    run_txn(0, 1, 32'h2000_0003, 32'h1234_5678, 4, 0, 0, st, wc, rc, bc, ro, ba, bw, be, hg);
    n_checks++;
    if (ba !== 32'h2000_0000 || bw !== 32'h1234_5678 || be !== 4'hF) begin
      n_errors++;
      $display("FAIL wr_bus_fields: got addr=%h data=%h be=%h required 20000000/12345678/f", ba, bw, be);
    end
    n_checks++;
    if (wc !== 5 || rc !== 0) begin
      n_errors++; $display("FAIL wr_strobe_len: got write=%0d read=%0d required 5/0", wc, rc);
    end
    n_checks++;
    if (hg !== 1'b0 || st !== 6) begin
      n_errors++; $display("FAIL wr_stall: got %0d (hung=%b) required 6", st, hg);
    end
  endtask

  task automatic test_write_after_read();
    int st, wc, rc, bc, es, erc, ewc;
    logic [31:0] ro, ba, bw, ero;
    logic [3:0] be;
    logic hg;
    model_step(1, 0, 32'h3000_0010, 0, 1, 32'hAAAA_0001, 0, es, erc, ewc, ero);
    run_txn(1, 0, 32'h3000_0010, 0, 0, 1, 32'hAAAA_0001, st, wc, rc, bc, ro, ba, bw, be, hg);
    model_step(0, 1, 32'h3000_0010, 0, 0, 0, 0, es, erc, ewc, ero);
    run_txn(0, 1, 32'h3000_0010, 32'h0BAD_0BAD, 0, 0, 0, st, wc, rc, bc, ro, ba, bw, be, hg);
    n_checks++;
    if (st !== 2 || ro !== 32'd0) begin
      n_errors++; $display("FAIL war_write: got stall=%0d data=%h required 2/0", st, ro);
    end
    model_step(1, 0, 32'h3000_0010, 0, 1, 32'hBBBB_0002, 0, es, erc, ewc, ero);
    run_txn(1, 0, 32'h3000_0010, 0, 0, 1, 32'hBBBB_0002, st, wc, rc, bc, ro, ba, bw, be, hg);
    n_checks++;
    if (rc !== 1 || st !== 3 || ro !== 32'hBBBB_0002) begin
      n_errors++;
      $display("FAIL war_refetch: got rd_cycles=%0d stall=%0d data=%h required 1/3/bbbb0002", rc, st, ro);
    end
  endtask

  task automatic test_simultaneous();
    int st, wc, rc, bc, es, erc, ewc;
    logic [31:0] ro, ba, bw, ero;
    logic [3:0] be;
    logic hg;
    model_step(1, 1, 32'h4000_0008, 1, 0, 0, 0, es, erc, ewc, ero);
    run_txn(1, 1, 32'h4000_0008, 32'h7777_1111, 1, 0, 32'h9999_9999, st, wc, rc, bc, ro, ba, bw, be, hg);
    n_checks++;
    if (wc !== 2 || rc !== 0 || bc !== 0 || st !== 3) begin
      n_errors++;
      $display("FAIL simul_write_only: got wr=%0d rd=%0d both=%0d stall=%0d required 2/0/0/3", wc, rc, bc, st);
    end
  endtask

  task automatic test_random();
    int st, wc, rc, bc, es, erc, ewc, waits, lat, op;
    logic [31:0] ro, ba, bw, ero, addr, rdata, wdata;
    logic [3:0] be;
    logic hg, rd, wr;
    logic [31:0] pool [4];
    pool[0] = 32'h0000_1000; pool[1] = 32'h0000_2004; pool[2] = 32'h8000_0008; pool[3] = 32'hFFFF_FFF0;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 4);
      rd = (op != 2) && (op != 3);
      wr = (op == 2) || (op == 4);
      addr = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      waits = $urandom_range(0, 3);
      lat = $urandom_range(0, 3);
      rdata = $urandom;
      wdata = $urandom;
      model_step(rd, wr, addr, waits, lat, rdata, 0, es, erc, ewc, ero);
      run_txn(rd, wr, addr, wdata, waits, lat, rdata, st, wc, rc, bc, ro, ba, bw, be, hg);
      n_checks++;
      if (hg !== 1'b0 || st !== es) begin
        n_errors++; $display("FAIL rnd_stall[%0d]: got %0d (hung=%b) required %0d", i, st, hg, es);
      end
      n_checks++;
      if (rc !== erc || wc !== ewc || bc !== 0) begin
        n_errors++;
        $display("FAIL rnd_strobes[%0d]: got rd=%0d wr=%0d both=%0d required %0d/%0d/0", i, rc, wc, bc, erc, ewc);
      end
      n_checks++;
      if (ro !== ero) begin
        n_errors++; $display("FAIL rnd_readdata[%0d]: got %h required %h", i, ro, ero);
      end
      if (erc + ewc > 0) begin
        n_checks++;
        if (ba !== (addr & 32'hFFFF_FFFC) || (wr && bw !== wdata)) begin
          n_errors++;
          $display("FAIL rnd_bus[%0d]: got addr=%h data=%h required %h/%h", i, ba, bw, addr & 32'hFFFF_FFFC, wdata);
        end
      end
      n_checks++;
      if (bus_error !== m_err) begin
        n_errors++; $display("FAIL rnd_bus_error[%0d]: got %b required %b", i, bus_error, m_err);
      end
    end
  endtask

  task automatic test_timeout();
    int st, wc, rc, bc, es, erc, ewc;
    logic [31:0] ro, ba, bw, ero;
    logic [3:0] be;
    logic hg;
    model_step(1, 0, 32'h5000_0000, 1000, 0, 0, 1, es, erc, ewc, ero);
    run_txn(1, 0, 32'h5000_0000, 0, 1000, 0, 32'h1111_2222, st, wc, rc, bc, ro, ba, bw, be, hg);
    n_checks++;
    if (hg !== 1'b0 || rc !== 8 || st !== 9) begin
      n_errors++;
      $display("FAIL tmo_abort: got rd_cycles=%0d stall=%0d hung=%b required 8/9/0", rc, st, hg);
    end
    n_checks++;
    if (bus_error !== 1'b1 || ro !== 32'd0) begin
      n_errors++; $display("FAIL tmo_flags: got err=%b data=%h required 1/0", bus_error, ro);
    end
    model_step(1, 0, 32'h5000_0040, 0, 1, 32'h600D_DA7A, 0, es, erc, ewc, ero);
    run_txn(1, 0, 32'h5000_0040, 0, 0, 1, 32'h600D_DA7A, st, wc, rc, bc, ro, ba, bw, be, hg);
    n_checks++;
    if (st !== 3 || ro !== 32'h600D_DA7A || bus_error !== 1'b1) begin
      n_errors++;
      $display("FAIL tmo_recover: got stall=%0d data=%h err=%b required 3/600dda7a/1", st, ro, bus_error);
    end
  endtask

  task automatic test_reset_mid_read();
    int st, wc, rc, bc, es, erc, ewc;
    logic [31:0] ro, ba, bw, ero;
    logic [3:0] be;
    logic hg;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h6000_0020;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({avm_read, avm_write, avm_address, avm_writedata, cpu_readdata, bus_error, cpu_stall} !== '0) begin
      n_errors++;
      $display("FAIL midrst_outputs: got rd=%b wr=%b addr=%h wd=%h rdata=%h err=%b stall=%b required all 0",
               avm_read, avm_write, avm_address, avm_writedata, cpu_readdata, bus_error, cpu_stall);
    end
    m_valid = 1'b0; m_err = 1'b0;
    cpu_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    #1;
    n_checks++;
    if (cpu_readdata !== 32'd0 || cpu_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_late_valid: got data=%h stall=%b required 0/0", cpu_readdata, cpu_stall);
    end
    @(negedge clk);
    model_step(1, 0, 32'h6000_0020, 0, 1, 32'h0F0F_0F0F, 0, es, erc, ewc, ero);
    run_txn(1, 0, 32'h6000_0020, 0, 0, 1, 32'h0F0F_0F0F, st, wc, rc, bc, ro, ba, bw, be, hg);
    n_checks++;
    if (st !== es || rc !== erc || ro !== ero || bus_error !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_fresh: got stall=%0d rd=%0d data=%h err=%b required %0d/%0d/%h/0",
               st, rc, ro, bus_error, es, erc, ero);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_zero_wait_read();
    test_write_waits();
    test_write_after_read();
    test_simultaneous();
    test_random();
    test_timeout();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
